// File: rtl/key_poller_pkg.sv
// Shared types and constants for the key PIO poller: FSM states, PIO address, key count.
package key_poller_pkg;

    localparam int         KEY_W         = 4;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        UPDATE
    } poll_state_t;

endpackage

// File: rtl/key_debounce.sv
// Whole-vector debouncer: commits a new key state after DEBOUNCE_CNT identical samples.
module key_debounce
    import key_poller_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic [KEY_W-1:0] sample,
    output logic [KEY_W-1:0] state,
    output logic             commit
);

    localparam logic [3:0] CNT_TOP = 4'(DEBOUNCE_CNT);

    logic [KEY_W-1:0] prev_sample_reg;
    logic [KEY_W-1:0] state_reg;
    logic [3:0]       count_reg;
    logic [3:0]       count_next;

    always_comb begin
        count_next = 4'd1;
        if (sample == prev_sample_reg) begin
            count_next = (count_reg == CNT_TOP) ? count_reg : count_reg + 4'd1;
        end
    end

    // Combinational so the top can compute edges against the pre-commit state.
    assign commit = sample_en && (count_next == CNT_TOP) && (sample != state_reg);
    assign state  = state_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_sample_reg <= '0;
            state_reg       <= '0;
            count_reg       <= '0;
        end else if (sample_en) begin
            prev_sample_reg <= sample;
            count_reg       <= count_next;
            if (commit) begin
                state_reg <= sample;
            end
        end
    end

endmodule

// File: rtl/key_pio_poller.sv
// Avalon-MM poller for the key PIO: scheduled reads, debounce, press-event slot.
// Optional release events are enabled by defining KEY_POLLER_RELEASE_EVT_EN.
module key_pio_poller
    import key_poller_pkg::*;
#(
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    output logic [KEY_W-1:0] key_state,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [KEY_W-1:0] event_keys,
    output logic             event_overrun
`ifdef KEY_POLLER_RELEASE_EVT_EN
    ,
    output logic             event_release
`endif
);

    localparam int               CNT_W     = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_reg;
    logic             tick;
    poll_state_t      state_reg;
    logic             avm_read_reg;
    logic [KEY_W-1:0] sample_reg;
    logic             update_en;
    logic [KEY_W-1:0] key_state_w;
    logic             commit;
    logic [KEY_W-1:0] press_mask;
    logic [KEY_W-1:0] new_mask;
    logic             new_rel;
    logic             dropped;
    logic             ev_valid_reg, ev_valid_next;
    logic [KEY_W-1:0] ev_keys_reg, ev_keys_next;
    logic             ev_ovr_reg, ev_ovr_next;
    logic             ev_rel_reg, ev_rel_next;
    logic             unused_readdata;

    assign unused_readdata = ^avm_readdata[31:KEY_W];

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // The PIO registers readdata at the end of ISSUE, so it is valid during WAIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            avm_read_reg <= 1'b0;
            sample_reg   <= '0;
        end else begin
            avm_read_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_reg    <= ISSUE;
                        avm_read_reg <= 1'b1;
                    end
                end
                ISSUE:  state_reg <= WAIT;
                WAIT: begin
                    sample_reg <= ~avm_readdata[KEY_W-1:0];
                    state_reg  <= UPDATE;
                end
                UPDATE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign update_en = (state_reg == UPDATE);

    key_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (update_en),
        .sample    (sample_reg),
        .state     (key_state_w),
        .commit    (commit)
    );

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_press
        assign press_mask[gi] = commit & sample_reg[gi] & ~key_state_w[gi];
    end

`ifdef KEY_POLLER_RELEASE_EVT_EN
    logic [KEY_W-1:0] release_mask;

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_release
        assign release_mask[gi] = commit & key_state_w[gi] & ~sample_reg[gi];
    end

    // A press wins over a simultaneous release; the release is dropped and flagged.
    assign new_mask = (press_mask != '0) ? press_mask : release_mask;
    assign new_rel  = (press_mask == '0);
    assign dropped  = (press_mask != '0) && (release_mask != '0);
`else
    assign new_mask = press_mask;
    assign new_rel  = 1'b0;
    assign dropped  = 1'b0;
`endif

    always_comb begin
        ev_valid_next = ev_valid_reg;
        ev_keys_next  = ev_keys_reg;
        ev_ovr_next   = ev_ovr_reg;
        ev_rel_next   = ev_rel_reg;
        if (ev_valid_reg && event_ready) begin
            ev_valid_next = 1'b0;
            ev_keys_next  = '0;
            ev_ovr_next   = 1'b0;
            ev_rel_next   = 1'b0;
        end
        if (new_mask != '0) begin
            if (!ev_valid_reg || event_ready) begin
                ev_valid_next = 1'b1;
                ev_keys_next  = new_mask;
                ev_ovr_next   = dropped;
                ev_rel_next   = new_rel;
            end else if (ev_rel_reg == new_rel) begin
                ev_keys_next = ev_keys_reg | new_mask;
                ev_ovr_next  = 1'b1;
            end else begin
                // Type mismatch: the newer event replaces the stale one.
                ev_keys_next = new_mask;
                ev_ovr_next  = 1'b1;
                ev_rel_next  = new_rel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ev_valid_reg <= 1'b0;
            ev_keys_reg  <= '0;
            ev_ovr_reg   <= 1'b0;
            ev_rel_reg   <= 1'b0;
        end else begin
            ev_valid_reg <= ev_valid_next;
            ev_keys_reg  <= ev_keys_next;
            ev_ovr_reg   <= ev_ovr_next;
            ev_rel_reg   <= ev_rel_next;
        end
    end

    assign avm_address   = PIO_DATA_ADDR;
    assign avm_read      = avm_read_reg;
    assign key_state     = key_state_w;
    assign event_valid   = ev_valid_reg;
    assign event_keys    = ev_keys_reg;
    assign event_overrun = ev_ovr_reg;
`ifdef KEY_POLLER_RELEASE_EVT_EN
    assign event_release = ev_rel_reg;
`endif

endmodule

// File: tb/tb_key_pio_poller.sv
// Scoreboard bench for key_pio_poller with a registered-readdata PIO model.
module tb_key_pio_poller;

    typedef struct {
        logic [3:0] keys;
        logic       ovr;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic [3:0]  key_state;
    logic        event_valid;
    logic        event_ready;
    logic [3:0]  event_keys;
    logic        event_overrun;
`ifdef KEY_POLLER_RELEASE_EVT_EN
    logic        event_release;
`endif

    logic [3:0]  raw_keys;
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_rd = 0;
    int          polls = 0;
    logic        ev_prev = 1'b0;

    key_pio_poller #(
        .POLL_DIV     (8),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avm_address   (avm_address),
        .avm_read      (avm_read),
        .avm_readdata  (avm_readdata),
        .key_state     (key_state),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_keys    (event_keys),
        .event_overrun (event_overrun)
`ifdef KEY_POLLER_RELEASE_EVT_EN
        ,
        .event_release (event_release)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave: readdata registered on the read strobe, upper bits carry junk.
    initial avm_readdata = 32'h5A5A_5A5F;
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= {28'h5A5A_5A5, raw_keys};
    end

    always @(posedge clk) begin
        if (!reset_n) cyc = 0;
        else          cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus timing, event latency and the scoreboard are checked away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_rd = 0;
            ev_prev = 1'b0;
        end else begin
            if (avm_read) begin
                check("rd_addr", 32'(avm_address), 32'd0);
                check("rd_period", 32'(cyc - last_rd), 32'd8);
                last_rd = cyc;
                polls++;
            end
            if (event_valid && !ev_prev) check("ev_latency", 32'(cyc - last_rd), 32'd3);
            if (event_valid && event_ready) begin
                $display("event transfer keys=%h overrun=%0d cycle=%0d", event_keys, event_overrun, cyc);
                if (exp_q.size() == 0) begin
                    check("ev_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ev_keys", 32'(event_keys), 32'(e.keys));
                    check("ev_overrun", 32'(event_overrun), 32'(e.ovr));
                end
            end
            ev_prev = event_valid;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the n-th read strobe, i.e. during WAIT.
    task automatic wait_polls(input int n);
        int target;
        target = polls + n;
        for (int i = 0; i < n * 8 + 20 && polls < target; i++) @(posedge clk);
        #1;
        if (polls < target) check("poll_timeout", 32'(polls), 32'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read"},  32'(avm_read),      32'd0);
        check({tag, "_state"}, 32'(key_state),     32'd0);
        check({tag, "_valid"}, 32'(event_valid),   32'd0);
        check({tag, "_keys"},  32'(event_keys),    32'd0);
        check({tag, "_ovr"},   32'(event_overrun), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset_n     = 1'b0;
        raw_keys    = 4'hF;
        event_ready = 1'b1;
        wait_cycles(2);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // Idle keys: polling only
        wait_polls(4);
        check("idle_state", 32'(key_state), 32'd0);
        check("idle_valid", 32'(event_valid), 32'd0);

        // Bouncing key never commits
        for (int i = 0; i < 3; i++) begin
            raw_keys = 4'hE;
            wait_polls(1);
            raw_keys = 4'hF;
            wait_polls(1);
        end
        wait_cycles(3);
        check("bounce_state", 32'(key_state), 32'd0);
        check("bounce_valid", 32'(event_valid), 32'd0);

        // Stable press of key0
        raw_keys = 4'hE;
        exp_q.push_back('{keys: 4'h1, ovr: 1'b0});
        wait_polls(3);
        wait_cycles(2);
        check("press_state", 32'(key_state), 32'h1);
        check("press_valid", 32'(event_valid), 32'd1);
        check("press_keys", 32'(event_keys), 32'h1);
        wait_cycles(1);
        check("press_clear", 32'(event_valid), 32'd0);

        // Release is silent
        raw_keys = 4'hF;
        wait_polls(3);
        wait_cycles(3);
        check("rel_state", 32'(key_state), 32'd0);
        check("rel_valid", 32'(event_valid), 32'd0);

        // Merge into a pending event
        event_ready = 1'b0;
        raw_keys    = 4'hE;
        exp_q.push_back('{keys: 4'h5, ovr: 1'b1});
        wait_polls(3);
        wait_cycles(2);
        check("pend_keys", 32'(event_keys), 32'h1);
        check("pend_ovr", 32'(event_overrun), 32'd0);
        raw_keys = 4'hA;
        wait_polls(3);
        wait_cycles(2);
        check("merge_state", 32'(key_state), 32'h5);
        check("merge_keys", 32'(event_keys), 32'h5);
        check("merge_ovr", 32'(event_overrun), 32'd1);
        event_ready = 1'b1;
        wait_cycles(1);
        check("merge_clr_valid", 32'(event_valid), 32'd0);
        check("merge_clr_keys", 32'(event_keys), 32'd0);
        check("merge_clr_ovr", 32'(event_overrun), 32'd0);

        // Transfer and new commit on the same edge
        raw_keys = 4'hF;
        wait_polls(3);
        wait_cycles(3);
        event_ready = 1'b0;
        raw_keys    = 4'hE;
        exp_q.push_back('{keys: 4'h1, ovr: 1'b0});
        wait_polls(3);
        wait_cycles(2);
        raw_keys = 4'hC;
        exp_q.push_back('{keys: 4'h2, ovr: 1'b0});
        wait_polls(3);
        wait_cycles(1);
        event_ready = 1'b1;
        wait_cycles(1);
        check("fresh_valid", 32'(event_valid), 32'd1);
        check("fresh_keys", 32'(event_keys), 32'h2);
        check("fresh_ovr", 32'(event_overrun), 32'd0);
        wait_cycles(1);
        check("fresh_clear", 32'(event_valid), 32'd0);

        // Reset during WAIT of the would-be committing poll
        raw_keys = 4'hF;
        wait_polls(3);
        wait_cycles(3);
        raw_keys = 4'h0;
        wait_polls(2);
        wait_polls(1);
        reset_n = 1'b0;
        wait_cycles(1);
        reset_n = 1'b1;
        check_idle_outputs("wait_rst");
        p0 = polls;
        wait_cycles(20);
        check("rst_polls", 32'(polls - p0), 32'd2);
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_state", 32'(key_state), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
